read_stage_p: RTL and testbench
===============================

READ_STAGE_P -- requirements
Module: read_stage_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width (32 or 64).
REQ-002 SHALL have parameter AW, default 5, meaning register address width; register count NREG = 2**AW, with x0 hard-wired to zero.
REQ-003 SHALL have port clk  in  1  meaning sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset, synchronous, active-high.
REQ-005 SHALL have ports ir_in  in  32 (instruction); pc_in  in  XLEN (its PC); v_in  in  1 (upstream valid); r_out  out  1 (ready to upstream).
REQ-006 SHALL have ports ir_out  out  32; pc_out  out  XLEN; a_out  out  XLEN (rs1 operand); b_out  out  XLEN (rs2 operand); i_out  out  XLEN (immediate); v_out  out  1 (downstream valid); r_in  in  1 (downstream ready).
REQ-007 SHALL have ports wb_v  in  1 (writeback valid); wb_addr  in  AW (destination); wb_data  in  XLEN (value to write).
REQ-008 SHALL have port flush  in  1, meaning discard the held output instruction.

Function
REQ-009 Transfer in SHALL occur on a cycle with v_in && r_out; transfer out SHALL occur on a cycle with v_out && r_in.
REQ-010 r_out SHALL be combinational: (!v_out || r_in) && !hazard && !flush.
REQ-011 Each output register SHALL hold its value, and v_out SHALL stay high, until transfer out; latency in to out SHALL be 1 cycle.
REQ-012 On a cycle with wb_v && wb_addr!=0, registers[wb_addr] SHALL take wb_data; writes to x0 SHALL be ignored.
REQ-013 Operand read SHALL use bypass priority: source==0 -> 0; else (wb_v && wb_addr==source) -> wb_data; else registers[source].
REQ-014 rs1 = ir_in[19:15] and rs2 = ir_in[24:20]; a_out SHALL be 0 for LUI, AUIPC and JAL.
REQ-015 i_out SHALL be formed per opcode (shared definition macros): LUI/AUIPC {ir[31:12],12'b0}; JAL J-type; JALR/LOAD/IM_ALU I-type; BRANCH B-type; STORE S-type; all sign-extended to XLEN. IM_ALU shifts SHALL give a zero-extended shamt of ir[24:20] (XLEN=32) or ir[25:20] (XLEN=64); other opcodes SHALL give 0.
REQ-016 A flush SHALL clear v_out on the next edge; input SHALL NOT be accepted in a flush cycle.
REQ-017 When a transfer in and a transfer out occur in the same cycle, the new instruction SHALL replace the old one with no bubble.

Reset
REQ-018 With rst high at an edge: v_out, ir_out, pc_out, a_out, b_out, i_out and all scoreboard bits SHALL be 0; register file contents other than x0 are undefined; rst SHALL override flush, writeback and transfers.

Configuration
REQ-019 Macro READ_STAGE_SCOREBOARD_EN SHALL gate the scoreboard: NREG busy bits, with busy[x0] always 0.
REQ-020 With the macro defined, accepting an rd-writing instruction (LUI, AUIPC, JAL, JALR, LOAD, IM_ALU, ALU; rd=ir[11:7]!=0) SHALL set busy[rd]; wb_v SHALL clear busy[wb_addr]; set SHALL win over clear on the same register in the same cycle; flush SHALL clear busy[rd] of the discarded instruction.
REQ-021 With the macro defined, hazard SHALL be: (rs1 used && busy[rs1] && !(wb_v && wb_addr==rs1)) || (rs2 used && busy[rs2] && !(wb_v && wb_addr==rs2)).
REQ-022 rs1 SHALL count as used by JALR, BRANCH, LOAD, STORE, IM_ALU and ALU; rs2 by BRANCH, STORE and ALU.
REQ-023 Without the macro, hazard SHALL be constant 0 and no busy state SHALL exist.

Verification
REQ-024 Bench SHALL cover: x5=0x1234 written, then ADDI x6,x5,-1 issued -> a_out=0x1234, i_out=0xFFFFFFFF, v_out high one cycle after accept.
REQ-025 Bench SHALL cover: wb_v=1, wb_addr=7, wb_data=0xCAFE in the same cycle ADD x1,x7,x7 is accepted -> a_out=b_out=0xCAFE.
REQ-026 Bench SHALL cover: r_in held low 3 cycles with v_out=1 -> outputs stable, r_out=0; r_in high with v_in high -> back-to-back transfer, no bubble.
REQ-027 Bench SHALL cover (macro on): LW x3 accepted, then ADD x4,x3,x0 presented -> r_out=0 until wb_v with wb_addr=3, accepted that same cycle with a_out=wb_data.
REQ-028 Bench SHALL cover: flush while LW x3 is held -> v_out=0 next cycle and busy[3]=0; rst mid-stall -> all outputs 0 and r_out=1 next cycle.
REQ-029 Bench SHALL cover (XLEN=64): BEQ with offset -8 -> i_out=0xFFFFFFFFFFFFFFF8; SLLI shamt 40 -> i_out=40.

Source files
------------

// File: rtl/read_stage_p.sv
// ============================================================================
// read_stage_p
// ----------------------------------------------------------------------------
// Register-read pipeline stage. Takes one instruction (and its PC) from the
// upstream stage, reads its rs1/rs2 operands from the register file with
// writeback bypass, forms the sign-extended immediate, and holds the result
// in output registers until the downstream stage accepts it. Valid/ready
// handshakes on both sides; a single-entry output buffer with 1-cycle
// latency that allows back-to-back transfers.
//
// Optional feature (build macro READ_STAGE_SCOREBOARD_EN):
//   Per-register busy bits. An accepted rd-writing instruction marks its rd
//   busy, writeback clears it, and an instruction whose used source is busy
//   (and not being written back this very cycle) is held off. Without the
//   macro there is no busy state and the stage never stalls on a hazard.
//
// Parameters
//   XLEN    datapath width (32 or 64)
//   AW      register address width; NREG = 2**AW registers, x0 reads zero
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   ir_in     in   32-bit instruction from upstream
//   pc_in     in   PC of ir_in
//   v_in      in   upstream valid
//   r_out     out  ready to upstream (combinational)
//   ir_out    out  held instruction
//   pc_out    out  held PC
//   a_out     out  rs1 operand (0 for LUI/AUIPC/JAL)
//   b_out     out  rs2 operand
//   i_out     out  immediate
//   v_out     out  downstream valid
//   r_in      in   downstream ready
//   wb_v      in   writeback valid
//   wb_addr   in   writeback destination register
//   wb_data   in   writeback value
//   flush     in   discard the held output instruction
// ============================================================================

`ifndef RSP_OPC_LUI
`define RSP_OPC_LUI    7'b0110111
`define RSP_OPC_AUIPC  7'b0010111
`define RSP_OPC_JAL    7'b1101111
`define RSP_OPC_JALR   7'b1100111
`define RSP_OPC_BRANCH 7'b1100011
`define RSP_OPC_LOAD   7'b0000011
`define RSP_OPC_STORE  7'b0100011
`define RSP_OPC_IM_ALU 7'b0010011
`define RSP_OPC_ALU    7'b0110011
`endif

// Raw (not yet extended) immediate fields; the sign bit is always the MSB.
`ifndef RSP_IMM_I
`define RSP_IMM_I(ir) {ir[31:20]}
`define RSP_IMM_S(ir) {ir[31:25], ir[11:7]}
`define RSP_IMM_B(ir) {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}
`define RSP_IMM_U(ir) {ir[31:12], 12'b0}
`define RSP_IMM_J(ir) {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}
`endif

module read_stage_p #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [31:0]     ir_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            v_in,
    output logic            r_out,

    output logic [31:0]     ir_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] a_out,
    output logic [XLEN-1:0] b_out,
    output logic [XLEN-1:0] i_out,
    output logic            v_out,
    input  logic            r_in,

    input  logic            wb_v,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,

    input  logic            flush
);

    localparam int NREG = 2 ** AW;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [6:0]    opc;
    logic [2:0]    funct3;
    logic [AW-1:0] rs1_a;
    logic [AW-1:0] rs2_a;
    logic          no_rs1;

    assign opc    = ir_in[6:0];
    assign funct3 = ir_in[14:12];
    assign rs1_a  = AW'(ir_in[19:15]);
    assign rs2_a  = AW'(ir_in[24:20]);

    // U/J formats have immediate bits where rs1 would be; force a_out to 0.
    assign no_rs1 = (opc == `RSP_OPC_LUI) || (opc == `RSP_OPC_AUIPC) ||
                    (opc == `RSP_OPC_JAL);

    // ------------------------------------------------------------------
    // Register file (no reset: contents other than x0 undefined after rst)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst && wb_v && (wb_addr != '0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Operand read with writeback bypass: x0 -> 0, then writeback, then RF
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        rs1_val = '0;
        if (rs1_a == '0) begin
            rs1_val = '0;
        end else if (wb_v && (wb_addr == rs1_a)) begin
            rs1_val = wb_data;
        end else begin
            rs1_val = rf_q[rs1_a];
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2_a == '0) begin
            rs2_val = '0;
        end else if (wb_v && (wb_addr == rs2_a)) begin
            rs2_val = wb_data;
        end else begin
            rs2_val = rf_q[rs2_a];
        end
    end

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] imm_val;

    // RV64 shifts carry a 6-bit shamt; RV32 only 5 bits.
    assign shamt = (XLEN == 32) ? XLEN'(ir_in[24:20]) : XLEN'(ir_in[25:20]);

    always_comb begin
        imm_val = '0;
        case (opc)
            `RSP_OPC_LUI,
            `RSP_OPC_AUIPC:  imm_val = XLEN'($signed(`RSP_IMM_U(ir_in)));
            `RSP_OPC_JAL:    imm_val = XLEN'($signed(`RSP_IMM_J(ir_in)));
            `RSP_OPC_JALR,
            `RSP_OPC_LOAD:   imm_val = XLEN'($signed(`RSP_IMM_I(ir_in)));
            `RSP_OPC_IM_ALU: begin
                // SLLI (001) and SRLI/SRAI (101) use the shift-amount field
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    imm_val = shamt;
                end else begin
                    imm_val = XLEN'($signed(`RSP_IMM_I(ir_in)));
                end
            end
            `RSP_OPC_BRANCH: imm_val = XLEN'($signed(`RSP_IMM_B(ir_in)));
            `RSP_OPC_STORE:  imm_val = XLEN'($signed(`RSP_IMM_S(ir_in)));
            default:         imm_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic hazard;
    logic accept;
    logic v_q, v_d;

    assign r_out  = (!v_q || r_in) && !hazard && !flush;
    assign accept = v_in && r_out;

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] a_q,  a_d;
    logic [XLEN-1:0] b_q,  b_d;
    logic [XLEN-1:0] i_q,  i_d;

    always_comb begin
        v_d  = v_q;
        ir_d = ir_q;
        pc_d = pc_q;
        a_d  = a_q;
        b_d  = b_q;
        i_d  = i_q;
        if (accept) begin
            // Also covers simultaneous transfer out: new entry replaces old.
            v_d  = 1'b1;
            ir_d = ir_in;
            pc_d = pc_in;
            a_d  = no_rs1 ? '0 : rs1_val;
            b_d  = rs2_val;
            i_d  = imm_val;
        end else if (flush || (v_q && r_in)) begin
            v_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= 1'b0;
            ir_q <= '0;
            pc_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            i_q  <= '0;
        end else begin
            v_q  <= v_d;
            ir_q <= ir_d;
            pc_q <= pc_d;
            a_q  <= a_d;
            b_q  <= b_d;
            i_q  <= i_d;
        end
    end

    assign v_out  = v_q;
    assign ir_out = ir_q;
    assign pc_out = pc_q;
    assign a_out  = a_q;
    assign b_out  = b_q;
    assign i_out  = i_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
`ifdef READ_STAGE_SCOREBOARD_EN

    function automatic logic writes_rd(input logic [6:0] op);
        writes_rd = (op == `RSP_OPC_LUI)  || (op == `RSP_OPC_AUIPC)  ||
                    (op == `RSP_OPC_JAL)  || (op == `RSP_OPC_JALR)   ||
                    (op == `RSP_OPC_LOAD) || (op == `RSP_OPC_IM_ALU) ||
                    (op == `RSP_OPC_ALU);
    endfunction

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW-1:0]   rd_in_a;
    logic [AW-1:0]   rd_held_a;
    logic            rs1_used;
    logic            rs2_used;

    assign rd_in_a   = AW'(ir_in[11:7]);
    assign rd_held_a = AW'(ir_q[11:7]);

    assign rs1_used = (opc == `RSP_OPC_JALR)   || (opc == `RSP_OPC_BRANCH) ||
                      (opc == `RSP_OPC_LOAD)   || (opc == `RSP_OPC_STORE)  ||
                      (opc == `RSP_OPC_IM_ALU) || (opc == `RSP_OPC_ALU);
    assign rs2_used = (opc == `RSP_OPC_BRANCH) || (opc == `RSP_OPC_STORE) ||
                      (opc == `RSP_OPC_ALU);

    // A busy source being written back this cycle is satisfied by the bypass.
    assign hazard = (rs1_used && busy_q[rs1_a] && !(wb_v && (wb_addr == rs1_a))) ||
                    (rs2_used && busy_q[rs2_a] && !(wb_v && (wb_addr == rs2_a)));

    always_comb begin
        busy_d = busy_q;
        if (wb_v) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (flush && v_q && writes_rd(ir_q[6:0])) begin
            busy_d[rd_held_a] = 1'b0;
        end
        // Applied last so a new claim wins over a same-cycle writeback clear.
        if (accept && writes_rd(opc) && (rd_in_a != '0)) begin
            busy_d[rd_in_a] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`else

    assign hazard = 1'b0;

`endif

endmodule

// File: tb/tb_read_stage_p.sv
// Self-checking bench for read_stage_p. Two instances (XLEN=32 and XLEN=64)
// share one stimulus stream; a behavioural model predicts both.
module tb_read_stage_p;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_ALU    = 7'h33;

    localparam logic [31:0] I_ADDI_X6  = 32'hFFF28313; // addi x6,x5,-1
    localparam logic [31:0] I_ADD_X1   = 32'h007380B3; // add  x1,x7,x7
    localparam logic [31:0] I_ADDI_X8  = 32'h00100413; // addi x8,x0,1
    localparam logic [31:0] I_ADDI_X9  = 32'h00200493; // addi x9,x0,2
    localparam logic [31:0] I_ADDI_X10 = 32'h00300513; // addi x10,x0,3
    localparam logic [31:0] I_LW_X3    = 32'h00002183; // lw   x3,0(x0)
    localparam logic [31:0] I_ADD_X4   = 32'h00018233; // add  x4,x3,x0
    localparam logic [31:0] I_BEQ_M8   = 32'hFE000CE3; // beq  x0,x0,-8
    localparam logic [31:0] I_SLLI_40  = 32'h02809093; // slli x1,x1,40

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v_in, r_in, wb_v, flush;
    logic [31:0] ir_in;
    logic [63:0] pc_in, wb_data;
    logic [4:0]  wb_addr;

    logic        r32, v32, r64, v64;
    logic [31:0] ir32, pc32, a32, b32, i32;
    logic [31:0] ir64;
    logic [63:0] pc64, a64, b64, i64;

    read_stage_p #(.XLEN(32), .AW(5)) u32 (
        .clk(clk), .rst(rst), .ir_in(ir_in), .pc_in(pc_in[31:0]), .v_in(v_in),
        .r_out(r32), .ir_out(ir32), .pc_out(pc32), .a_out(a32), .b_out(b32),
        .i_out(i32), .v_out(v32), .r_in(r_in), .wb_v(wb_v), .wb_addr(wb_addr),
        .wb_data(wb_data[31:0]), .flush(flush)
    );

    read_stage_p #(.XLEN(64), .AW(5)) u64 (
        .clk(clk), .rst(rst), .ir_in(ir_in), .pc_in(pc_in), .v_in(v_in),
        .r_out(r64), .ir_out(ir64), .pc_out(pc64), .a_out(a64), .b_out(b64),
        .i_out(i64), .v_out(v64), .r_in(r_in), .wb_v(wb_v), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [63:0] mregs [32];
    bit          mv;
    logic [31:0] mir;
    logic [63:0] mpc, ma, mb, mi64;
    logic [31:0] mi32;
`ifdef READ_STAGE_SCOREBOARD_EN
    bit          mbusy [32];
`endif
    logic        r32_mid, r64_mid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Immediate as a signed integer, built from weighted bit fields.
    function automatic longint imm_of(input logic [31:0] ir, input int xlen);
        longint v;
        longint neg;
        v = 0;
        case (ir[6:0])
            OP_LUI, OP_AUIPC: begin
                neg = ir[31] ? 64'sd4294967296 : 64'sd0;
                v = 4096 * longint'(ir[31:12]) - neg;
            end
            OP_JAL: begin
                neg = ir[31] ? 64'sd1048576 : 64'sd0;
                v = 4096 * longint'(ir[19:12]) + 2048 * longint'(ir[20])
                  + 2 * longint'(ir[30:21]) - neg;
            end
            OP_JALR, OP_LOAD: begin
                neg = ir[31] ? 64'sd2048 : 64'sd0;
                v = longint'(ir[30:20]) - neg;
            end
            OP_IMM: begin
                if (ir[14:12] == 3'd1 || ir[14:12] == 3'd5) begin
                    v = (xlen == 32) ? longint'(ir[24:20]) : longint'(ir[25:20]);
                end else begin
                    neg = ir[31] ? 64'sd2048 : 64'sd0;
                    v = longint'(ir[30:20]) - neg;
                end
            end
            OP_BRANCH: begin
                neg = ir[31] ? 64'sd4096 : 64'sd0;
                v = 2048 * longint'(ir[7]) + 32 * longint'(ir[30:25])
                  + 2 * longint'(ir[11:8]) - neg;
            end
            OP_STORE: begin
                neg = ir[31] ? 64'sd2048 : 64'sd0;
                v = 32 * longint'(ir[30:25]) + longint'(ir[11:7]) - neg;
            end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] opnd(input logic [4:0] s);
        if (s == 5'd0) return 64'd0;
        if (wb_v && wb_addr == s) return wb_data;
        return mregs[s];
    endfunction

`ifdef READ_STAGE_SCOREBOARD_EN
    function automatic bit writes_rd(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_ALU};
    endfunction
    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_ALU};
    endfunction
    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {OP_BRANCH, OP_STORE, OP_ALU};
    endfunction
`endif

    function automatic bit m_hazard();
`ifdef READ_STAGE_SCOREBOARD_EN
        logic [4:0] s1, s2;
        s1 = ir_in[19:15];
        s2 = ir_in[24:20];
        return (uses_rs1(ir_in[6:0]) && mbusy[s1] && !(wb_v && wb_addr == s1)) ||
               (uses_rs2(ir_in[6:0]) && mbusy[s2] && !(wb_v && wb_addr == s2));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input bit acc);
        longint     imm;
        logic [4:0] s1, s2;
        s1 = ir_in[19:15];
        s2 = ir_in[24:20];
        if (rst) begin
            mv = 0; mir = '0; mpc = '0; ma = '0; mb = '0; mi64 = '0; mi32 = '0;
`ifdef READ_STAGE_SCOREBOARD_EN
            for (int k = 0; k < 32; k++) mbusy[k] = 0;
`endif
        end else begin
`ifdef READ_STAGE_SCOREBOARD_EN
            if (wb_v) mbusy[wb_addr] = 0;
            if (flush && mv && writes_rd(mir[6:0])) mbusy[mir[11:7]] = 0;
            if (acc && writes_rd(ir_in[6:0]) && ir_in[11:7] != 5'd0) mbusy[ir_in[11:7]] = 1;
`endif
            if (acc) begin
                mv   = 1;
                mir  = ir_in;
                mpc  = pc_in;
                ma   = (ir_in[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL}) ? 64'd0 : opnd(s1);
                mb   = opnd(s2);
                imm  = imm_of(ir_in, 64);
                mi64 = imm;
                imm  = imm_of(ir_in, 32);
                mi32 = imm[31:0];
            end else if (flush || (mv && r_in)) begin
                mv = 0;
            end
            if (wb_v && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        end
    endtask

    // One clock: check ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cycle();
        bit exp_r, acc, was_rst;
        #2;
        exp_r   = (!mv || r_in) && !m_hazard() && !flush;
        r32_mid = r32;
        r64_mid = r64;
        chk("r_out32", 64'(r32), 64'(exp_r));
        chk("r_out64", 64'(r64), 64'(exp_r));
        acc     = v_in && exp_r;
        was_rst = rst;
        model_step(acc);
        @(posedge clk);
        #1;
        chk("v_out32", 64'(v32), 64'(mv));
        chk("v_out64", 64'(v64), 64'(mv));
        if (mv || was_rst) begin
            chk("ir_out32", 64'(ir32), 64'(mir));
            chk("pc_out32", 64'(pc32), 64'(mpc[31:0]));
            chk("a_out32",  64'(a32),  64'(ma[31:0]));
            chk("b_out32",  64'(b32),  64'(mb[31:0]));
            chk("i_out32",  64'(i32),  64'(mi32));
            chk("ir_out64", 64'(ir64), 64'(mir));
            chk("pc_out64", pc64, mpc);
            chk("a_out64",  a64,  ma);
            chk("b_out64",  b64,  mb);
            chk("i_out64",  i64,  mi64);
        end
    endtask

    task automatic idle();
        rst = 0; v_in = 0; r_in = 1; wb_v = 0; flush = 0;
    endtask

    task automatic init_regs();
        idle();
        for (int i = 1; i < 32; i++) begin
            wb_v    = 1;
            wb_addr = 5'(i);
            wb_data = {$urandom(), $urandom()};
            cycle();
        end
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1; v_in = 0; r_in = 1; wb_v = 0; wb_addr = '0; wb_data = '0;
        flush = 0; ir_in = '0; pc_in = '0;
        mv = 0; mir = '0; mpc = '0; ma = '0; mb = '0; mi64 = '0; mi32 = '0;
        for (int k = 0; k < 32; k++) mregs[k] = '0;
`ifdef READ_STAGE_SCOREBOARD_EN
        for (int k = 0; k < 32; k++) mbusy[k] = 0;
`endif
        @(posedge clk);
        #1;
        cycle();
        chk("rst_v_out", 64'(v32), 64'd0);
        chk("rst_ir_out", 64'(ir32), 64'd0);
        chk("rst_r_out", 64'(r32_mid), 64'd1);

        init_regs();

        // x5 = 0x1234, then addi x6,x5,-1
        wb_v = 1; wb_addr = 5'd5; wb_data = 64'h1234;
        cycle();
        idle(); v_in = 1; ir_in = I_ADDI_X6; pc_in = 64'h1000; r_in = 0;
        cycle();
        chk("addi_a", 64'(a32), 64'h1234);
        chk("addi_i32", 64'(i32), 64'hFFFF_FFFF);
        chk("addi_i64", i64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_v", 64'(v32), 64'd1);
        idle();
        cycle();

        // writeback bypass into add x1,x7,x7
        v_in = 1; ir_in = I_ADD_X1; pc_in = 64'h1004;
        wb_v = 1; wb_addr = 5'd7; wb_data = 64'hCAFE;
        cycle();
        chk("bypass_a", 64'(a32), 64'hCAFE);
        chk("bypass_b", 64'(b32), 64'hCAFE);
        idle();
        cycle();

        // stall 3 cycles, then back-to-back
        v_in = 1; ir_in = I_ADDI_X8; r_in = 0;
        cycle();
        ir_in = I_ADDI_X9;
        repeat (3) begin
            cycle();
            chk("stall_r_out", 64'(r32_mid), 64'd0);
            chk("stall_ir", 64'(ir32), 64'(I_ADDI_X8));
            chk("stall_v", 64'(v32), 64'd1);
        end
        r_in = 1;
        cycle();
        chk("b2b_ir1", 64'(ir32), 64'(I_ADDI_X9));
        ir_in = I_ADDI_X10;
        cycle();
        chk("b2b_ir2", 64'(ir32), 64'(I_ADDI_X10));
        chk("b2b_v", 64'(v32), 64'd1);
        idle();
        cycle();

`ifdef READ_STAGE_SCOREBOARD_EN
        // RAW hazard on a load destination, released by writeback
        v_in = 1; ir_in = I_LW_X3;
        cycle();
        ir_in = I_ADD_X4;
        repeat (3) begin
            cycle();
            chk("hazard_r_out", 64'(r32_mid), 64'd0);
        end
        wb_v = 1; wb_addr = 5'd3; wb_data = 64'hBEEF;
        cycle();
        chk("hazard_release_r", 64'(r32_mid), 64'd1);
        chk("hazard_release_a", 64'(a32), 64'hBEEF);
        idle();
        cycle();
`endif

        // flush of held load, then reset mid-stall
        v_in = 1; ir_in = I_LW_X3; r_in = 0;
        cycle();
        chk("flush_pre_v", 64'(v32), 64'd1);
        idle(); r_in = 0; flush = 1;
        cycle();
        chk("flush_v", 64'(v32), 64'd0);
        idle(); v_in = 1; ir_in = I_ADD_X4; r_in = 0;
        cycle();
        chk("flush_busy_clr", 64'(r32_mid), 64'd1);
        cycle();
        rst = 1;
        cycle();
        chk("rst_mid_v", 64'(v32), 64'd0);
        chk("rst_mid_ir", 64'(ir32), 64'd0);
        chk("rst_mid_a", a64, 64'd0);
        chk("rst_mid_i", i64, 64'd0);
        idle();
        cycle();
        chk("rst_mid_r_out", 64'(r32_mid), 64'd1);
        init_regs();

        // immediates
        v_in = 1; ir_in = I_BEQ_M8;
        cycle();
        chk("beq_i64", i64, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("beq_i32", 64'(i32), 64'hFFFF_FFF8);
        ir_in = I_SLLI_40;
        cycle();
        chk("slli_i64", i64, 64'd40);
        chk("slli_i32", 64'(i32), 64'd8);
        idle();
        cycle();

        // randomized traffic
        repeat (2000) begin
            int unsigned pick;
            logic [6:0]  ops [9];
            ops[0] = OP_LUI;  ops[1] = OP_AUIPC; ops[2] = OP_JAL;
            ops[3] = OP_JALR; ops[4] = OP_BRANCH; ops[5] = OP_LOAD;
            ops[6] = OP_STORE; ops[7] = OP_IMM;  ops[8] = OP_ALU;
            pick    = $urandom_range(0, 9);
            ir_in   = $urandom();
            if (pick < 9) ir_in[6:0] = ops[pick];
            pc_in   = {$urandom(), $urandom()};
            v_in    = ($urandom_range(0, 3) != 0);
            r_in    = ($urandom_range(0, 2) != 0);
            wb_v    = $urandom_range(0, 1) == 1;
            wb_addr = 5'($urandom());
            wb_data = {$urandom(), $urandom()};
            flush   = ($urandom_range(0, 11) == 0);
            rst     = 0;
            cycle();
        end

        idle();
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
